sub_operand_seq: RTL
====================

SUB_OPERAND_SEQ -- requirements
Module: sub_operand_seq

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 4, number of clocks operands are held on the subtractor before the result is sampled (legal range 1..7).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid input 1, in_ready output 1 -- operand-pair handshake.
REQ-005 SHALL have ports: in_a input 4, in_b input 4 -- minuend and subtrahend, qualified by in_valid.
REQ-006 SHALL have ports: sub_a output 4, sub_b output 4 -- registered operands driven into the downstream subtractor.
REQ-007 SHALL have ports: sub_s input 4, sub_neg input 1 -- subtractor magnitude |a-b| and sign (1 = a<b).
REQ-008 SHALL have ports: out_valid output 1, out_ready input 1 -- result handshake.
REQ-009 SHALL have ports: out_mag output 4, out_neg output 1 -- captured sign-magnitude result.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, SETTLE, HOLD; one-hot or binary encoding at implementer's choice.
REQ-012 SHALL assert in_ready only in IDLE; in_ready is a function of state only.
REQ-013 SHALL, in IDLE with in_valid=1, register in_a/in_b into sub_a/sub_b, load settle counter with SETTLE_CYCLES-1, and go to SETTLE on that edge.
REQ-014 SHALL hold sub_a/sub_b constant from accept until the next accept; in_a/in_b changes outside the accept edge are ignored.
REQ-015 SHALL decrement the settle counter each clock in SETTLE; when counter is 0, capture sub_s into out_mag and sub_neg into out_neg and go to HOLD.
REQ-016 SHALL give latency: accept at edge T, out_valid high from edge T+SETTLE_CYCLES (SETTLE_CYCLES=1 -> out_valid one cycle after accept).
REQ-017 SHALL keep out_valid=1 and out_mag/out_neg stable in HOLD until out_ready=1 is sampled; on that edge go to IDLE and deassert out_valid.
REQ-018 SHALL force out_neg=0 whenever the captured magnitude is 0 (no negative zero).
REQ-019 SHALL not accept a new pair in the same edge that a result is consumed; earliest next accept is the cycle after HOLD exits.
REQ-020 SHALL retain out_mag/out_neg after HOLD exit until the next capture; only out_valid qualifies them.
REQ-021 SHALL treat out_ready in IDLE/SETTLE and in_valid outside IDLE as don't-care with no state effect.

Reset
REQ-022 SHALL, with rst=1 on a clock edge, go to IDLE regardless of state, including mid-SETTLE and HOLD; any in-flight result is discarded.
REQ-023 SHALL reset values: sub_a=0, sub_b=0, out_mag=0, out_neg=0, out_valid=0, busy=0, settle counter=0; in_ready=1 from first post-reset cycle.
REQ-024 SHALL give rst priority over simultaneous in_valid or out_ready.

Configuration
REQ-025 SHALL, with macro SUB_SEQ_STATS_EN defined, add output neg_count (8 bits): count of results captured with out_neg=1, incremented at the capture edge, saturating at 255, cleared by rst.
REQ-026 SHALL, without SUB_SEQ_STATS_EN, omit port neg_count and all its logic; all other behaviour identical.

Verification
REQ-027 SHALL check: in_a=9, in_b=3, SETTLE_CYCLES=4, out_ready=1 -> sub_a=9/sub_b=3 one edge after accept; out_valid 4 cycles after accept with out_mag=6, out_neg=0.
REQ-028 SHALL check: in_a=3, in_b=9 -> out_mag=6, out_neg=1; with SUB_SEQ_STATS_EN, neg_count 0->1.
REQ-029 SHALL check: in_a=5, in_b=5, model driving sub_neg=1 erroneously -> out_mag=0, out_neg=0.
REQ-030 SHALL check backpressure: out_ready=0 for 6 cycles in HOLD -> out_valid=1, out_mag/out_neg unchanged, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-031 SHALL check reset mid-operation: rst pulsed in second SETTLE cycle -> next cycle IDLE, out_valid=0, sub_a=sub_b=0, no result produced.
REQ-032 SHALL check saturation (SUB_SEQ_STATS_EN): 256 consecutive negative results -> neg_count holds at 255.

Source files
------------

// File: rtl/sub_operand_seq.sv
`default_nettype none
// ============================================================================
// Module   : sub_operand_seq
// Purpose  : Sequences one operand pair at a time into an external 4-bit
//            subtractor. Accepted operands are registered onto sub_a/sub_b,
//            held for SETTLE_CYCLES clocks, and then the subtractor's
//            sign-magnitude answer is captured and offered on a
//            valid/ready output until consumed.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - operand-pair handshake (ready only in IDLE)
//            in_a, in_b          - minuend / subtrahend
//            sub_a, sub_b        - registered operands to the subtractor
//            sub_s, sub_neg      - subtractor |a-b| and sign (1 = a<b)
//            out_valid/out_ready - result handshake
//            out_mag, out_neg    - captured result (never negative zero)
//            neg_count           - saturating count of negative results
//                                  (only when SUB_SEQ_STATS_EN is defined)
//            busy                - high whenever not IDLE
// Options  : `define SUB_SEQ_STATS_EN adds the neg_count output and counter.
// Revision : 1.0 - initial release
// ============================================================================
module sub_operand_seq #(
    parameter int SETTLE_CYCLES = 4    // legal range 1..7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] sub_a,
    output logic [3:0] sub_b,
    input  logic [3:0] sub_s,
    input  logic       sub_neg,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_mag,
    output logic       out_neg,
`ifdef SUB_SEQ_STATS_EN
    output logic [7:0] neg_count,
`endif
    output logic       busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_hold   = 2'd2;

    // Counter is loaded with SETTLE_CYCLES-1 so that the capture edge lands
    // exactly SETTLE_CYCLES edges after the accept edge.
    localparam logic [2:0] c_settle_init = 3'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [2:0] r_cnt;
    logic [3:0] r_sub_a;
    logic [3:0] r_sub_b;
    logic [3:0] r_out_mag;
    logic       r_out_neg;

    logic       w_accept;
    logic       w_capture;
    logic       w_cap_neg;

    assign w_accept  = (r_state == c_st_idle) && in_valid;
    assign w_capture = (r_state == c_st_settle) && (r_cnt == 3'd0);
    // A zero magnitude is always reported positive, whatever the subtractor
    // claims for the sign.
    assign w_cap_neg = sub_neg && (sub_s != 4'd0);

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    w_next_state = c_st_settle;
                end
            end
            c_st_settle: begin
                if (r_cnt == 3'd0) begin
                    w_next_state = c_st_hold;
                end
            end
            c_st_hold: begin
                if (out_ready) begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // State, operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= 3'd0;
            r_sub_a   <= 4'd0;
            r_sub_b   <= 4'd0;
            r_out_mag <= 4'd0;
            r_out_neg <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_sub_a <= in_a;
                r_sub_b <= in_b;
                r_cnt   <= c_settle_init;
            end else if ((r_state == c_st_settle) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end

            // Result registers keep their value after HOLD exits; only
            // out_valid says whether they are current.
            if (w_capture) begin
                r_out_mag <= sub_s;
                r_out_neg <= w_cap_neg;
            end
        end
    end

`ifdef SUB_SEQ_STATS_EN
    logic [7:0] r_neg_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_count <= 8'd0;
        end else if (w_capture && w_cap_neg && (r_neg_count != 8'hFF)) begin
            r_neg_count <= r_neg_count + 8'd1;
        end
    end

    assign neg_count = r_neg_count;
`endif

    assign in_ready  = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign out_valid = (r_state == c_st_hold);
    assign sub_a     = r_sub_a;
    assign sub_b     = r_sub_b;
    assign out_mag   = r_out_mag;
    assign out_neg   = r_out_neg;

endmodule
`default_nettype wire
